alu_pipe_ctrl: RTL and testbench

Two-stage pipelined 32-bit ALU datapath controller with valid/ready handshakes on both sides. It decodes a 4-bit ALU control code into per-slice invert, carry-in and operation fields, and drives 32 instances of the team's 1-bit slice `alu_top`. It resolves carries from the slices' p/g outputs with 4-bit lookahead groups. The result, zero, carry-out and overflow flags are registered toward the writeback/branch logic.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_pipe_ctrl_cla4.sv | 22 ++
 rtl/alu_top.sv | 37 +++
 rtl/alu_pipe_ctrl.sv | 134 +++++++++++++
 tb/tb_alu_pipe_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes, decoded control bundle and lookahead group size.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_LESS = 2'b11;

  localparam int CLA_GROUP = 4;

  typedef struct packed {
    logic       a_inv;
    logic       b_inv;
    logic       cin;
    logic [1:0] op;
  } alu_dec_t;

  function automatic alu_dec_t alu_decode(input logic [3:0] ctrl);
    alu_dec_t d;
    d.a_inv = ctrl[3];
    d.b_inv = ctrl[2];
    d.cin   = ctrl[2];
    d.op    = ctrl[1:0];
    return d;
  endfunction

endpackage

// File: rtl/alu_pipe_ctrl_cla4.sv
// Four-bit carry lookahead group: internal carries plus group P/G
// used to ripple between groups.
module cla4 (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       cin,
  output logic [4:1] c,
  output logic       pg,
  output logic       gg
);

  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (&p[1:0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (&p[2:1] & g[0])
              | (&p[2:0] & cin);
  assign c[4] = gg | (pg & cin);

  assign pg = &p;
  assign gg = g[3] | (p[3] & g[2]) | (&p[3:2] & g[1])
            | (&p[3:1] & g[0]);

endmodule

// File: rtl/alu_top.sv
// One-bit ALU slice: optional operand inversion, and/or/sum/less select,
// exporting propagate/generate for the external lookahead network.
module alu_top
  import alu_pkg::*;
(
  input  logic       src1,
  input  logic       src2,
  input  logic       less,
  input  logic       a_invert,
  input  logic       b_invert,
  input  logic       cin,
  input  logic [1:0] operation,
  output logic       result,
  output logic       p,
  output logic       g
);

  logic w_a;
  logic w_b;

  assign w_a = src1 ^ a_invert;
  assign w_b = src2 ^ b_invert;
  assign p   = w_a ^ w_b;
  assign g   = w_a & w_b;

  always_comb begin
    result = 1'b0;
    unique case (operation)
      OP_AND:  result = w_a & w_b;
      OP_OR:   result = w_a | w_b;
      OP_ADD:  result = p ^ cin;
      OP_LESS: result = less;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_pipe_ctrl.sv
// Two-stage pipelined ALU with valid/ready on both sides.
// Define ALU_PIPE_BYPASS_EN to drop the operand stage (latency 1).
module alu_pipe_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  localparam int NG = WIDTH / CLA_GROUP;

  logic             w_s2_adv;
  logic             w_v;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [3:0]       w_ctrl;
  alu_dec_t         w_dec;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH:0]   w_c;
  logic [NG-1:0]    w_gp;
  logic [NG-1:0]    w_gg;
  logic [NG:0]      w_gc;
  logic             w_ovf;
  logic             w_set;

  assign w_s2_adv = !out_valid || out_ready;

`ifdef ALU_PIPE_BYPASS_EN
  assign w_a      = src1;
  assign w_b      = src2;
  assign w_ctrl   = alu_ctrl;
  assign w_v      = in_valid;
  assign in_ready = !rst_i && w_s2_adv;
`else
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_ctrl;
  logic             r_s1_valid;

  assign in_ready = !rst_i && (!r_s1_valid || w_s2_adv);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_a    <= src1;
        r_b    <= src2;
        r_ctrl <= alu_ctrl;
      end
    end
  end

  assign w_a    = r_a;
  assign w_b    = r_b;
  assign w_ctrl = r_ctrl;
  assign w_v    = r_s1_valid;
`endif

  assign w_dec  = alu_decode(w_ctrl);
  assign w_c[0] = w_dec.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    alu_top u_slice (
      .src1      (w_a[i]),
      .src2      (w_b[i]),
      .less      ((i == 0) ? w_set : 1'b0),
      .a_invert  (w_dec.a_inv),
      .b_invert  (w_dec.b_inv),
      .cin       (w_c[i]),
      .operation (w_dec.op),
      .result    (w_res[i]),
      .p         (w_p[i]),
      .g         (w_g[i])
    );
  end

  for (genvar k = 0; k < NG; k++) begin : g_cla
    cla4 u_cla (
      .p   (w_p[4*k +: 4]),
      .g   (w_g[4*k +: 4]),
      .cin (w_gc[k]),
      .c   (w_c[4*k+4 : 4*k+1]),
      .pg  (w_gp[k]),
      .gg  (w_gg[k])
    );
  end

  // Group carries ripple from group P/G in one block.
  always_comb begin
    w_gc[0] = w_dec.cin;
    for (int k = 0; k < NG; k++) begin
      w_gc[k+1] = w_gg[k] | (w_gp[k] & w_gc[k]);
    end
  end

  assign w_ovf = w_c[WIDTH-1] ^ w_c[WIDTH];
  assign w_set = w_p[WIDTH-1] ^ w_c[WIDTH-1] ^ w_ovf;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
    end else if (w_s2_adv) begin
      out_valid <= w_v;
      if (w_v) begin
        result   <= w_res;
        zero     <= (w_res == '0);
        cout     <= w_dec.op[1] & w_c[WIDTH];
        overflow <= w_dec.op[1] & w_ovf;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe_ctrl.sv
// Self-checking bench for alu_pipe_ctrl: directed cases, backpressure,
// reset flush and random traffic against an arithmetic reference model.
module tb_alu_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [3:0]  alu_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        cout;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  logic [34:0] exp_q[$];
  logic [31:0] got[$];
  bit          hold_prev = 1'b0;
  logic [31:0] held;

`ifdef ALU_PIPE_BYPASS_EN
  localparam int LAT = 1;
  localparam int CAP = 1;
`else
  localparam int LAT = 2;
  localparam int CAP = 2;
`endif

  localparam longint MAXP = 64'sd2147483647;
  localparam longint MINN = -64'sd2147483648;

  always #5 clk = ~clk;

  alu_pipe_ctrl #(.WIDTH(32)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src1      (src1),
    .src2      (src2),
    .alu_ctrl  (alu_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .cout      (cout),
    .overflow  (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: {result, zero, cout, overflow} from plain arithmetic.
  function automatic logic [34:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [3:0]  c);
    logic [31:0] aa;
    logic [31:0] bb;
    logic [32:0] s;
    longint      t;
    longint      ci;
    logic        ovf;
    logic        set;
    logic [31:0] r;
    aa  = c[3] ? ~a : a;
    bb  = c[2] ? ~b : b;
    ci  = c[2] ? 64'sd1 : 64'sd0;
    s   = {1'b0, aa} + {1'b0, bb} + {32'd0, c[2]};
    t   = longint'($signed(aa)) + longint'($signed(bb)) + ci;
    ovf = (t > MAXP) || (t < MINN);
    set = s[31] ^ ovf;
    case (c[1:0])
      2'b00:   r = aa & bb;
      2'b01:   r = aa | bb;
      2'b10:   r = s[31:0];
      default: r = {31'd0, set};
    endcase
    return {r, r == 32'd0, c[1] & s[32], c[1] & ovf};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [34:0] e;
    if (rst_i) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && out_valid) chk("hold_result", result, held);
      hold_prev = out_valid && !out_ready;
      held      = result;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $error("FAIL spurious_out observed=%h expected=none", result);
        end else begin
          e = exp_q.pop_front();
          chk("res", result, e[34:3]);
          chk("zero", {31'd0, zero}, {31'd0, e[2]});
          chk("cout", {31'd0, cout}, {31'd0, e[1]});
          chk("ovf", {31'd0, overflow}, {31'd0, e[0]});
        end
        got.push_back(result);
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(src1, src2, alu_ctrl));
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] c);
    bit acc = 1'b0;
    src1     = a;
    src2     = b;
    alu_ctrl = c;
    in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    src1     = $urandom;
    src2     = $urandom;
    alu_ctrl = 4'($urandom);
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $error("FAIL send_timeout observed=no_accept expected=accept");
    end
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $error("FAIL drain_timeout observed=%0d expected=0", exp_q.size());
    end
  endtask

  initial begin
    logic [31:0] ra[3];
    logic [31:0] rb[3];
    logic [3:0]  rc[3];
    logic [31:0] keep;
    int          idx;
    bit          acc;

    rst_i     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    src1      = '0;
    src2      = '0;
    alu_ctrl  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst_i = 1'b0;
    @(posedge clk);
    #1;

    // ADD overflow and latency
    send(32'h7FFF_FFFF, 32'h0000_0001, 4'b0010);
    chk("add_early_valid", {31'd0, out_valid}, {31'd0, LAT == 1});
    repeat (LAT - 1) begin
      @(posedge clk);
      #1;
    end
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_result", result, 32'h8000_0000);
    chk("add_ovf", {31'd0, overflow}, 32'd1);
    chk("add_cout", {31'd0, cout}, 32'd0);
    chk("add_zero", {31'd0, zero}, 32'd0);
    wait_drain();

    // SUB then SLT back-to-back
`ifdef ALU_PIPE_BYPASS_EN
    send(32'd5, 32'd5, 4'b0110);
    chk("sub_result", result, 32'd0);
    chk("sub_zero", {31'd0, zero}, 32'd1);
    chk("sub_cout", {31'd0, cout}, 32'd1);
    send(32'hFFFF_FFFF, 32'h0000_0001, 4'b0111);
`else
    send(32'd5, 32'd5, 4'b0110);
    send(32'hFFFF_FFFF, 32'h0000_0001, 4'b0111);
    chk("sub_result", result, 32'd0);
    chk("sub_zero", {31'd0, zero}, 32'd1);
    chk("sub_cout", {31'd0, cout}, 32'd1);
    @(posedge clk);
    #1;
`endif
    chk("slt_valid", {31'd0, out_valid}, 32'd1);
    chk("slt_result", result, 32'd1);
    wait_drain();

    // NOR / AND / OR
    got.delete();
    send(32'h0F0F_0F0F, 32'h00FF_00FF, 4'b1100);
    send(32'h0F0F_0F0F, 32'h00FF_00FF, 4'b0000);
    send(32'h0F0F_0F0F, 32'h00FF_00FF, 4'b0001);
    wait_drain();
    chk("logic_count", got.size(), 32'd3);
    chk("nor_result", got[0], 32'hF000_F000);
    chk("and_result", got[1], 32'h000F_000F);
    chk("or_result", got[2], 32'h0FFF_0FFF);

    // Backpressure: pipeline fills, then drains in order
    got.delete();
    ra = '{32'd1, 32'd10, 32'h8000_0000};
    rb = '{32'd2, 32'd3, 32'd1};
    rc = '{4'b0010, 4'b0110, 4'b0111};
    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1;
    src1 = ra[0];
    src2 = rb[0];
    alu_ctrl = rc[0];
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      if (idx < 3) begin
        src1 = ra[idx];
        src2 = rb[idx];
        alu_ctrl = rc[idx];
      end
    end
    chk("bp_accepted", idx, CAP);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    keep = result;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_stable", result, keep);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", {31'd0, in_ready}, 32'd1);
    for (int cyc = 0; cyc < 10 && idx < 3; cyc++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      if (idx < 3) begin
        src1 = ra[idx];
        src2 = rb[idx];
        alu_ctrl = rc[idx];
      end
    end
    in_valid = 1'b0;
    wait_drain();
    chk("bp_count", got.size(), 32'd3);
    chk("bp_res0", got[0], 32'd3);
    chk("bp_res1", got[1], 32'd7);
    chk("bp_res2", got[2], 32'd1);

    // Reset with the pipeline full
    out_ready = 1'b0;
    repeat (CAP) send(32'd1, 32'd1, 4'b0010);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_result", result, 32'd0);
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("mrst_in_ready2", {31'd0, in_ready}, 32'd0);
    exp_q.delete();
    rst_i = 1'b0;
    out_ready = 1'b1;
    got.delete();
    send(32'h1234_5678, 32'h1111_1111, 4'b0010);
    wait_drain();
    chk("post_rst_count", got.size(), 32'd1);
    chk("post_rst_res", got[0], 32'h2345_6789);

    // Random traffic with random backpressure
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (acc || !in_valid) begin
        if ($urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          src1 = pick();
          src2 = ($urandom_range(0, 4) == 0) ? src1 : pick();
          alu_ctrl = 4'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    chk("rand_queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
